// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer
// Time-multiplexed FIR filter. A single signed multiply-accumulate unit is
// stepped across TAPS coefficients for every accepted input sample, trading
// throughput (one sample per TAPS+2 cycles) for a single multiplier.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset
//   in_valid    in_data holds a sample
//   in_data     signed input sample (DATA_W)
//   in_ready    a sample is accepted at the next edge if in_valid is high
//   out_valid   one-cycle pulse, out_data updated
//   out_data    signed filtered sample (DATA_W), held until the next result
//   coef_we     coefficient write strobe
//   coef_addr   tap index to write
//   coef_data   signed coefficient value (DATA_W, COEF_FRAC fractional bits)
//   coef_ready  a coefficient write is taken at the next edge
//   busy        MAC sequence in progress
module fir_mac_sequencer #(
    parameter int DATA_W    = 8,
    parameter int TAPS      = 16,
    parameter int COEF_FRAC = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    input  logic                      coef_we,
    input  logic [$clog2(TAPS)-1:0]   coef_addr,
    input  logic [DATA_W-1:0]         coef_data,
    output logic                      coef_ready,
    output logic                      busy
);

    localparam int KW    = $clog2(TAPS);
    localparam int ACC_W = 2 * DATA_W + KW;
    localparam int PW    = 2 * DATA_W + 1;

    localparam logic [KW-1:0]             K_LAST   = KW'(TAPS - 1);
    localparam logic [KW:0]               TAPS_N   = (KW + 1)'(TAPS);
    localparam logic signed [ACC_W-1:0]   SAT_MAX  = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0]   SAT_MIN  = ACC_W'(-(1 << (DATA_W - 1)));
    // Unity gain (1 << COEF_FRAC) does not fit a DATA_W signed value, so the
    // bank keeps one extra bit; written coefficients are sign-extended into it.
    localparam logic signed [DATA_W:0]    H_UNITY  = (DATA_W + 1)'(1 << COEF_FRAC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_DONE
    } state_t;

    state_t                     r_state;
    state_t                     w_next;

    logic signed [DATA_W-1:0]   r_x [TAPS];
    logic signed [DATA_W:0]     r_h [TAPS];
    logic signed [ACC_W-1:0]    r_acc;
    logic [KW-1:0]              r_k;
    logic                       r_out_valid;
    logic [DATA_W-1:0]          r_out_data;

    logic                       w_accept;
    logic                       w_coef_wr;
    logic signed [PW-1:0]       w_x_ext;
    logic signed [PW-1:0]       w_h_ext;
    logic signed [PW-1:0]       w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic signed [ACC_W-1:0]    w_shift;
    logic [DATA_W-1:0]          w_sat;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignment so every register
        // samples the pre-edge values regardless of block ordering.
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned (no latch).
        w_next     = r_state;
        in_ready   = 1'b0;
        coef_ready = 1'b0;
        busy       = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready   = 1'b1;
                coef_ready = 1'b1;
                if (in_valid) w_next = S_MAC;
            end
            S_MAC: begin
                busy = 1'b1;
                if (r_k == K_LAST) w_next = S_DONE;
            end
            S_DONE: begin
                busy   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_accept  = in_ready && in_valid;
    // Addresses beyond the last tap (non power-of-two TAPS) are silently dropped.
    assign w_coef_wr = coef_we && coef_ready && ({1'b0, coef_addr} < TAPS_N);

    // ---------------- MAC datapath ----------------
    assign w_x_ext    = PW'(r_x[r_k]);
    assign w_h_ext    = PW'(r_h[r_k]);
    assign w_prod     = w_x_ext * w_h_ext;
    assign w_prod_ext = ACC_W'(w_prod);
    // Arithmetic shift: rounds toward minus infinity.
    assign w_shift    = r_acc >>> COEF_FRAC;

    always_comb begin
        w_sat = w_shift[DATA_W-1:0];
        if (w_shift > SAT_MAX)      w_sat = SAT_MAX[DATA_W-1:0];
        else if (w_shift < SAT_MIN) w_sat = SAT_MIN[DATA_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the delay line and coefficient bank are deliberately reset:
            // the filter must restart from silence with a pass-through response.
            for (int i = 0; i < TAPS; i++) begin
                r_x[i] <= '0;
                r_h[i] <= (i == 0) ? H_UNITY : '0;
            end
            r_acc       <= '0;
            r_k         <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_x[0] <= in_data;
                        for (int i = 1; i < TAPS; i++) r_x[i] <= r_x[i-1];
                        r_acc <= '0;
                        r_k   <= '0;
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + w_prod_ext;
                    r_k   <= r_k + KW'(1);
                end
                S_DONE: begin
                    r_out_data  <= w_sat;
                    r_out_valid <= 1'b1;
                end
                default: ;
            endcase
            // A write on the accept edge lands before the first MAC step reads it.
            if (w_coef_wr) r_h[coef_addr] <= (DATA_W + 1)'(signed'(coef_data));
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer
// Directed plus randomized bench for fir_mac_sequencer (TAPS=4). Expected
// outputs come from an arithmetic FIR model: sum of x[i]*h[i], floor-divided
// by 2^COEF_FRAC and clamped to the DATA_W signed range.
module tb_fir_mac_sequencer;

    localparam int DATA_W    = 8;
    localparam int TAPS      = 4;
    localparam int COEF_FRAC = 7;
    localparam int AW        = $clog2(TAPS);
    localparam int P         = TAPS + 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              coef_we;
    logic [AW-1:0]     coef_addr;
    logic [DATA_W-1:0] coef_data;
    logic              coef_ready;
    logic              busy;

    fir_mac_sequencer #(
        .DATA_W    (DATA_W),
        .TAPS      (TAPS),
        .COEF_FRAC (COEF_FRAC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .coef_ready (coef_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc = 0;
    int last_out = 0;
    int mx [TAPS];
    int mh [TAPS];
    int exp_q [$];

    // ---------- reference model ----------
    function automatic int model_out();
        int sum = 0;
        int y;
        for (int i = 0; i < TAPS; i++) sum += mx[i] * mh[i];
        y = sum >>> COEF_FRAC;
        if (y > (1 << (DATA_W - 1)) - 1) y = (1 << (DATA_W - 1)) - 1;
        if (y < -(1 << (DATA_W - 1)))    y = -(1 << (DATA_W - 1));
        return y;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < TAPS; i++) begin
            mx[i] = 0;
            mh[i] = 0;
        end
        mh[0] = 1 << COEF_FRAC;
    endfunction

    function automatic void model_accept(int v);
        for (int i = TAPS - 1; i > 0; i--) mx[i] = mx[i-1];
        mx[0] = v;
        exp_q.push_back(model_out());
    endfunction

    function automatic int rnd_s8();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    // ---------- helpers ----------
    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic accept(input int v);
        int n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk("in_ready_before_accept", in_ready, 1);
        in_valid = 1'b1;
        in_data  = DATA_W'(v);
        model_accept(v);
        step();
        in_valid = 1'b0;
        coef_we  = 1'b0;
        acc_cyc  = cyc;
        chk("busy_after_accept", busy, 1);
        chk("in_ready_after_accept", in_ready, 0);
        chk("out_valid_after_accept", out_valid, 0);
    endtask

    task automatic wait_out(input string tag);
        int n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk({tag, "_latency"}, cyc - acc_cyc, TAPS + 1);
        chk({tag, "_in_ready"}, in_ready, 1);
        last_out = int'($signed(out_data));
        chk({tag, "_data"}, $signed(out_data), exp_q.pop_front());
    endtask

    task automatic send(input int v, input string tag);
        accept(v);
        wait_out(tag);
    endtask

    task automatic wcoef(input int a, input int d);
        chk("coef_ready_idle", coef_ready, 1);
        coef_we   = 1'b1;
        coef_addr = AW'(a);
        coef_data = DATA_W'(d);
        step();
        coef_we   = 1'b0;
        mh[a]     = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        exp_q.delete();
    endtask

    int pass_in  [4] = '{5, -7, 127, -128};
    int avg_out  [5] = '{25, 25, 25, 25, 0};

    initial begin
        int v;
        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        model_reset();

        // Reset state
        repeat (3) step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        step();
        chk("rst_out_data", $signed(out_data), 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_coef_ready", coef_ready, 1);

        // Pass-through at maximum rate
        for (int i = 0; i < 4; i++) begin
            send(pass_in[i], "pass");
            chk("pass_const", last_out, pass_in[i]);
        end

        // Moving average: impulse response of four 0.25 taps
        for (int i = 0; i < TAPS; i++) wcoef(i, 32);
        for (int i = 0; i < TAPS; i++) send(0, "avg_flush");
        for (int i = 0; i < 5; i++) begin
            send((i == 0) ? 100 : 0, "avg");
            chk("avg_const", last_out, avg_out[i]);
        end

        // Saturation both directions
        for (int i = 0; i < TAPS; i++) wcoef(i, 127);
        for (int i = 0; i < TAPS; i++) send(127, "sat_pos");
        chk("sat_pos_const", last_out, 127);
        for (int i = 0; i < TAPS; i++) send(-128, "sat_neg");
        chk("sat_neg_const", last_out, -128);

        // Simultaneous coefficient write and sample accept
        do_reset();
        chk("simul_coef_ready", coef_ready, 1);
        coef_we = 1'b1; coef_addr = '0; coef_data = DATA_W'(64);
        mh[0] = 64;
        accept(50);
        wait_out("simul");
        chk("simul_const", last_out, 25);

        // Coefficient write during MAC must be ignored
        accept(rnd_s8());
        coef_we = 1'b1; coef_addr = '0; coef_data = DATA_W'(99);
        for (int i = 0; i < 2; i++) begin
            chk("coef_ready_mac", coef_ready, 0);
            step();
        end
        coef_we = 1'b0;
        wait_out("coef_blocked");
        send(rnd_s8(), "coef_blocked_next");

        // in_valid held high with a new sample every cycle
        for (int c = 0; c < 3 * P; c++) begin
            v = rnd_s8();
            in_valid = 1'b1;
            in_data  = DATA_W'(v);
            if (c % P == 0) model_accept(v);
            step();
            chk("hold_out_valid", out_valid, (c % P == P - 1) ? 1 : 0);
            chk("hold_in_ready", in_ready, (c % P == P - 1) ? 1 : 0);
            if (c % P == P - 1) chk("hold_data", $signed(out_data), exp_q.pop_front());
        end
        in_valid = 1'b0;

        // Randomized coefficients and samples
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 1) == 1) wcoef(int'($urandom_range(0, TAPS - 1)), rnd_s8());
            send(rnd_s8(), "rand");
        end

        // Reset in the middle of a MAC sequence
        wcoef(0, 32);
        accept(100);
        step();
        step();
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 1);
        step();
        rst = 1'b0;
        model_reset();
        exp_q.delete();
        for (int i = 0; i < TAPS + 4; i++) begin
            chk("midrst_no_out_valid", out_valid, 0);
            step();
        end
        wcoef(1, 64);
        send(9, "midrst");
        chk("midrst_const", last_out, 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
